bpf_sel_seq: RTL and testbench

- Parametrised successor to the fixed six-band BPF decoder.
- Maps tuned frequency (Hz/65536) to a band using a runtime-programmable edge/code table with hysteresis.
- Sequences relay changes break-before-make and asserts a receiver mute during switching.
- Keeps VHF I2C sharing on BPF bits 0/2 as open-drain enables; sits between the frequency register and the top-level BPF pins.

---
 rtl/bpf_sel_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_bpf_sel_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpf_sel_seq.sv
// Band-pass filter selector: maps tuned frequency to a band through a programmable
// edge/code table with hysteresis and sequences relays break-before-make under mute.
// Optional macro BPF_PTT_LOCK_EN freezes band changes while transmitting.
module bpf_sel_seq #(
    parameter int FREQ_W     = 16,
    parameter int NUM_BANDS  = 6,
    parameter int SEL_W      = 3,
    parameter int HYST       = 2,
    parameter int BREAK_CYC  = 4,
    parameter int SETTLE_CYC = 16,
    parameter int BREAK_CODE = 4,
    parameter int RESET_CODE = 7,
    localparam int BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [FREQ_W-1:0] freq,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [BAND_W-1:0] cfg_addr,
    input  logic [FREQ_W-1:0] cfg_data,
    input  logic              vhf,
    input  logic              vhf_sda,
    input  logic              vhf_scl,
    input  logic              ptt,
    output logic [SEL_W-1:0]  bpf_out,
    output logic [SEL_W-1:0]  bpf_oe,
    output logic              mute,
    output logic              busy,
    output logic [BAND_W-1:0] band
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_DECIDE = 3'd2;
    localparam logic [2:0] ST_BREAK  = 3'd3;
    localparam logic [2:0] ST_MAKE   = 3'd4;

    localparam int CNT_MAX = (BREAK_CYC > SETTLE_CYC) ? BREAK_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SEL_W-1:0]  BRK_CODE  = SEL_W'(BREAK_CODE);
    localparam logic [SEL_W-1:0]  RST_CODE  = SEL_W'(RESET_CODE);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);
    localparam logic [BAND_W-1:0] LAST_EDGE = BAND_W'(NUM_BANDS - 2);
    localparam logic [FREQ_W:0]   HYST_X    = (FREQ_W + 1)'(HYST);

    function automatic logic [FREQ_W-1:0] edge_default(input int i);
        case (i)
            0:       return FREQ_W'(38);
            1:       return FREQ_W'(91);
            2:       return FREQ_W'(191);
            3:       return FREQ_W'(305);
            4:       return FREQ_W'(534);
            default: return {FREQ_W{1'b1}};
        endcase
    endfunction

    function automatic logic [SEL_W-1:0] code_default(input int i);
        case (i)
            0:       return SEL_W'(6);
            1:       return SEL_W'(2);
            2:       return SEL_W'(0);
            3:       return SEL_W'(3);
            4:       return SEL_W'(1);
            default: return RST_CODE;
        endcase
    endfunction

    logic [FREQ_W-1:0] edge_tab [NUM_BANDS];
    logic [SEL_W-1:0]  code_tab [NUM_BANDS];

    logic [2:0]        state;
    logic [FREQ_W-1:0] freq_q, freq_s, last_eval;
    logic              eval_valid, cfg_pend;
    logic [BAND_W-1:0] scan_idx, target, band_q;
    logic [SEL_W-1:0]  code_q, next_code;
    logic              mute_q;
    logic [CNT_W-1:0]  cnt;

    logic              cfg_wr;
    logic [FREQ_W-1:0] edge_cur, edge_below;
    logic              go_up, go_dn;
    logic              ptt_hold, ptt_abort;

    assign cfg_wr = cfg_we && (32'(cfg_addr) < NUM_BANDS);

    // The last band is the open-ended bypass, so its edge entry stays at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                edge_tab[i] <= edge_default(i);
                code_tab[i] <= code_default(i);
            end
        end else if (cfg_wr) begin
            if (cfg_sel)
                code_tab[cfg_addr] <= cfg_data[SEL_W-1:0];
            else if (32'(cfg_addr) < NUM_BANDS - 1)
                edge_tab[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clock) begin
        freq_q <= freq;
    end

`ifdef BPF_PTT_LOCK_EN
    logic ptt_q;
    always_ff @(posedge clock) begin
        if (reset) ptt_q <= 1'b0;
        else       ptt_q <= ptt;
    end
    assign ptt_hold  = ptt;
    assign ptt_abort = ptt && !ptt_q;
`else
    logic unused_ptt;
    assign unused_ptt = ptt;
    assign ptt_hold   = 1'b0;
    assign ptt_abort  = 1'b0;
`endif

    // Hysteresis compares are one bit wider so edge + HYST cannot wrap.
    assign edge_cur   = edge_tab[band_q];
    assign edge_below = (band_q == '0) ? '0 : edge_tab[band_q - BAND_W'(1)];
    assign go_up = (target > band_q) && ({1'b0, freq_s} > ({1'b0, edge_cur} + HYST_X));
    assign go_dn = (target < band_q) && (({1'b0, freq_s} + HYST_X) <= {1'b0, edge_below});

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            freq_s     <= '0;
            last_eval  <= '0;
            eval_valid <= 1'b0;
            cfg_pend   <= 1'b0;
            scan_idx   <= '0;
            target     <= '0;
            band_q     <= LAST_BAND;
            code_q     <= RST_CODE;
            next_code  <= RST_CODE;
            mute_q     <= 1'b0;
            cnt        <= '0;
        end else begin
            if (cfg_wr) cfg_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!ptt_hold && (freq_q != last_eval || !eval_valid || cfg_pend)) begin
                        state      <= ST_SCAN;
                        freq_s     <= freq_q;
                        last_eval  <= freq_q;
                        eval_valid <= 1'b1;
                        cfg_pend   <= 1'b0;
                        scan_idx   <= '0;
                    end
                end
                ST_SCAN: begin
                    // An aborted evaluation is forgotten so it reruns once ptt drops.
                    if (ptt_abort) begin
                        state      <= ST_IDLE;
                        eval_valid <= 1'b0;
                    end else if (freq_s <= edge_tab[scan_idx]) begin
                        target <= scan_idx;
                        state  <= ST_DECIDE;
                    end else if (scan_idx == LAST_EDGE) begin
                        target <= LAST_BAND;
                        state  <= ST_DECIDE;
                    end else begin
                        scan_idx <= scan_idx + BAND_W'(1);
                    end
                end
                ST_DECIDE: begin
                    if (ptt_abort) begin
                        state      <= ST_IDLE;
                        eval_valid <= 1'b0;
                    end else if (go_up || go_dn) begin
                        state     <= ST_BREAK;
                        code_q    <= BRK_CODE;
                        next_code <= code_tab[target];
                        mute_q    <= 1'b1;
                        cnt       <= CNT_W'(BREAK_CYC - 1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    if (cnt == '0) begin
                        state  <= ST_MAKE;
                        code_q <= next_code;
                        band_q <= target;
                        cnt    <= CNT_W'(SETTLE_CYC - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_MAKE: begin
                    if (cnt == '0) begin
                        state  <= ST_IDLE;
                        mute_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // In VHF mode bits 0/2 become open-drain I2C lines: drive low or release.
    always_comb begin
        bpf_out = code_q;
        bpf_oe  = '1;
        if (vhf) begin
            bpf_out[0] = 1'b0;
            bpf_out[2] = 1'b0;
            bpf_oe[0]  = !vhf_sda;
            bpf_oe[2]  = !vhf_scl;
        end
    end

    assign mute = mute_q;
    assign busy = (state != ST_IDLE);
    assign band = band_q;

endmodule

// File: tb/tb_bpf_sel_seq.sv
// Directed bench for bpf_sel_seq: expected output transitions go into a queue and a
// negedge monitor pops one per observed change, also checking BREAK/MAKE hold lengths.
module tb_bpf_sel_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] freq;
    logic        cfg_we, cfg_sel;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        vhf, vhf_sda, vhf_scl, ptt;
    logic [2:0]  bpf_out, bpf_oe;
    logic        mute, busy;
    logic [2:0]  band;

    always #5 clock = ~clock;

    bpf_sel_seq dut (
        .clock(clock), .reset(reset), .freq(freq),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .vhf(vhf), .vhf_sda(vhf_sda), .vhf_scl(vhf_scl), .ptt(ptt),
        .bpf_out(bpf_out), .bpf_oe(bpf_oe), .mute(mute), .busy(busy), .band(band)
    );

    // Tuple = {band, bpf_out, bpf_oe, mute}; dur_q holds how long that tuple must last.
    logic [9:0] exp_q[$];
    int         dur_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic logic [9:0] tup(input int b, input int o, input int e, input int m);
        return {3'(b), 3'(o), 3'(e), 1'(m)};
    endfunction

    task automatic expect_out(input int b, input int o, input int e, input int m, input int d);
        exp_q.push_back(tup(b, o, e, m));
        dur_q.push_back(d);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg_write(input logic sel, input int addr, input int data);
        cfg_sel  = sel;
        cfg_addr = 3'(addr);
        cfg_data = 16'(data);
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic wait_for_mute(input int lim);
        int k;
        k = 0;
        while (!mute && k < lim) begin
            tick();
            k++;
        end
        check("mute_seen", int'(mute), 1);
    endtask

    task automatic wait_for_band(input int b, input int lim);
        int k;
        k = 0;
        while (int'(band) != b && k < lim) begin
            tick();
            k++;
        end
        check("band_reached", int'(band), b);
    endtask

    // Monitor
    logic       mon_en   = 1'b0;
    logic       mon_live = 1'b0;
    logic [9:0] prev_t;
    int         elapsed  = 0;
    int         prev_dur = 0;

    always @(negedge clock) begin
        logic [9:0] cur;
        logic [9:0] e;
        cur = {band, bpf_out, bpf_oe, mute};
        if (mon_en) begin
            if (!mon_live) begin
                prev_t   = cur;
                elapsed  = 1;
                prev_dur = 0;
                mon_live = 1'b1;
            end else if (cur !== prev_t) begin
                if (prev_dur != 0) check("hold_cycles", elapsed, prev_dur);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_change: got band=%0d out=%b oe=%b mute=%b, want no change",
                             cur[9:7], cur[6:4], cur[3:1], cur[0]);
                    prev_dur = 0;
                end else begin
                    e        = exp_q.pop_front();
                    prev_dur = dur_q.pop_front();
                    n_cmp++;
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL out_tuple: got band=%0d out=%b oe=%b mute=%b, want band=%0d out=%b oe=%b mute=%b",
                                 cur[9:7], cur[6:4], cur[3:1], cur[0], e[9:7], e[6:4], e[3:1], e[0]);
                    end
                end
                prev_t  = cur;
                elapsed = 1;
            end else begin
                elapsed++;
            end
        end
    end

    initial begin
        reset = 1'b1; freq = 16'd100;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        vhf = 1'b0; vhf_sda = 1'b0; vhf_scl = 1'b0; ptt = 1'b0;
        wait_cycles(3);
        check("reset_out", int'(bpf_out), 7);
        check("reset_oe", int'(bpf_oe), 7);
        check("reset_mute", int'(mute), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_band", int'(band), 5);
        mon_en = 1'b1;
        tick();

        // First scan after reset: 100 lands in band 2 (code 0)
        expect_out(5, 4, 7, 1, 4);
        expect_out(2, 0, 7, 1, 16);
        expect_out(2, 0, 7, 0, 0);
        reset = 1'b0;
        wait_cycles(40);
        check("init_band", int'(band), 2);
        check("init_busy", int'(busy), 0);
        check("init_drain", exp_q.size(), 0);

        // Hysteresis around edge[2] = 191
        freq = 16'd192; wait_cycles(20);
        freq = 16'd193; wait_cycles(20);
        check("hyst_hold_band", int'(band), 2);
        expect_out(2, 4, 7, 1, 4);
        expect_out(3, 3, 7, 1, 16);
        expect_out(3, 3, 7, 0, 0);
        freq = 16'd194; wait_cycles(40);
        check("hyst_up_band", int'(band), 3);
        freq = 16'd190; wait_cycles(20);
        check("hyst_stay_band", int'(band), 3);
        expect_out(3, 4, 7, 1, 4);
        expect_out(2, 0, 7, 1, 16);
        expect_out(2, 0, 7, 0, 0);
        freq = 16'd189; wait_cycles(40);
        check("hyst_down_band", int'(band), 2);
        check("hyst_drain", exp_q.size(), 0);

        // Reprogrammed edge[0] = 50 moves 45 into band 0
        cfg_write(1'b0, 0, 50);
        expect_out(2, 4, 7, 1, 4);
        expect_out(0, 6, 7, 1, 16);
        expect_out(0, 6, 7, 0, 0);
        freq = 16'd45; wait_cycles(40);
        check("edge_wr_band", int'(band), 0);

        // Code write rescans but leaves the current output alone
        cfg_write(1'b1, 0, 5);
        tick();
        check("code_wr_rescan", int'(busy), 1);
        wait_cycles(20);
        check("code_wr_out", int'(bpf_out), 6);
        check("code_wr_band", int'(band), 0);

        // VHF open-drain sharing on bits 0/2
        expect_out(0, 2, 7, 0, 0); vhf = 1'b1;     wait_cycles(2);
        expect_out(0, 2, 6, 0, 0); vhf_sda = 1'b1; wait_cycles(2);
        expect_out(0, 2, 2, 0, 0); vhf_scl = 1'b1; wait_cycles(2);
        expect_out(0, 2, 6, 0, 0); vhf_scl = 1'b0; wait_cycles(2);
        expect_out(0, 6, 7, 0, 0); vhf = 1'b0; vhf_sda = 1'b0; wait_cycles(2);
        check("vhf_drain", exp_q.size(), 0);

        // Frequency change during BREAK: band 2 completes, then band 3
        expect_out(0, 4, 7, 1, 4);
        expect_out(2, 0, 7, 1, 16);
        expect_out(2, 0, 7, 0, 0);
        expect_out(2, 4, 7, 1, 4);
        expect_out(3, 3, 7, 1, 16);
        expect_out(3, 3, 7, 0, 0);
        freq = 16'd100;
        wait_for_mute(20);
        freq = 16'd250;
        wait_cycles(70);
        check("mid_break_band", int'(band), 3);
        check("mid_break_drain", exp_q.size(), 0);

        // Reset in MAKE; afterwards default tables put 45 in band 1 (code 2)
        expect_out(3, 4, 7, 1, 4);
        expect_out(0, 5, 7, 1, 0);
        expect_out(5, 7, 7, 0, 0);
        expect_out(5, 4, 7, 1, 4);
        expect_out(1, 2, 7, 1, 16);
        expect_out(1, 2, 7, 0, 0);
        freq = 16'd45;
        wait_for_band(0, 30);
        wait_cycles(3);
        reset = 1'b1;
        tick();
        check("mid_reset_out", int'(bpf_out), 7);
        check("mid_reset_mute", int'(mute), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_band", int'(band), 5);
        reset = 1'b0;
        wait_cycles(40);
        check("post_reset_band", int'(band), 1);
        check("post_reset_drain", exp_q.size(), 0);

`ifdef BPF_PTT_LOCK_EN
        begin
            int k;
            ptt = 1'b1; freq = 16'd300;
            wait_cycles(30);
            check("ptt_lock_band", int'(band), 1);
            expect_out(1, 4, 7, 1, 4);
            expect_out(3, 3, 7, 1, 16);
            expect_out(3, 3, 7, 0, 0);
            ptt = 1'b0;
            k = 0;
            while (!busy && k < 2) begin
                tick();
                k++;
            end
            check("ptt_release_busy", int'(busy), 1);
            wait_cycles(40);
            check("ptt_release_band", int'(band), 3);
        end
`endif

        wait_cycles(5);
        check("final_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
